// File: rtl/fft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pkg : shared FFT sizing defaults and unload state encoding     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_M     = 9;
  localparam int FFT_N     = 1 << FFT_M;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } unload_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_reverse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bit_reverse : combinational M-bit index reversal                   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bit_reverse #(
  parameter int M = 9
) (
  input  logic [M-1:0] din,
  output logic [M-1:0] dout
);

  for (genvar i = 0; i < M; i++) begin : g_bit
    assign dout[i] = din[M-1-i];
  end

endmodule
`default_nettype wire

// File: rtl/mag_sq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mag_sq : full-precision re*re + im*im of a packed {re, im} word    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mag_sq #(
  parameter int width = 16
) (
  input  logic [2*width-1:0] data,
  output logic [2*width-1:0] mag
);

  logic signed [2*width-1:0] re_ext;
  logic signed [2*width-1:0] im_ext;
  logic signed [2*width-1:0] re_sq;
  logic signed [2*width-1:0] im_sq;

  assign re_ext = {{width{data[2*width-1]}}, data[2*width-1:width]};
  assign im_ext = {{width{data[width-1]}}, data[width-1:0]};

  // Each square is at most 2^(2w-2), so the unsigned sum never wraps.
  assign re_sq = re_ext * re_ext;
  assign im_sq = im_ext * im_ext;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule
`default_nettype wire

// File: rtl/fft_unloader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_unloader : streams a bit-reversed result RAM out in natural    |
// | bin order through a 2-entry buffer with valid/ready. rev 1.0       |
// +--------------------------------------------------------------------+
module fft_unloader
  import fft_pkg::*;
#(
  parameter int width = FFT_WIDTH,
  parameter int M     = FFT_M
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rd_en,
  output logic [M-1:0]       rd_addr,
  input  logic [2*width-1:0] rd_data,
  output logic [2*width-1:0] out_data,
  output logic [2*width-1:0] out_mag,
  output logic [M-1:0]       out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int N = 1 << M;

  unload_state_t      state;
  logic [M-1:0]       k;
  logic               pend;
  logic [M-1:0]       pend_idx;
  logic [1:0]         count;
  logic [2*width-1:0] slot1_data;
  logic [M-1:0]       slot1_idx;
  logic               xfer;
  logic               issue;
  logic [2:0]         occupancy;

  assign xfer = out_valid & out_ready;

  // Entries held plus the read whose data arrives this cycle, net of the
  // bin leaving now; a new read lands one cycle later, so this bounds the
  // buffer at two entries while still allowing one read per cycle.
  assign occupancy = 3'(count) + 3'(pend) - 3'(xfer);
  assign issue     = (state == RUN) && (occupancy < 3'd2);
  assign rd_en     = issue;
  assign busy      = (state != IDLE) | done;

  bit_reverse #(.M(M)) u_bit_reverse (
    .din  (k),
    .dout (rd_addr)
  );

  mag_sq #(.width(width)) u_mag_sq (
    .data (out_data),
    .mag  (out_mag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      pend       <= 1'b0;
      pend_idx   <= '0;
      count      <= 2'd0;
      slot1_data <= '0;
      slot1_idx  <= '0;
      out_data   <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      pend     <= issue;
      pend_idx <= k;

      case (state)
        IDLE: begin
          if (start && !done) begin
            state <= RUN;
            k     <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (k == M'(N - 1)) state <= FLUSH;
            else                k     <= k + M'(1);
          end
        end
        FLUSH: begin
          if (xfer && (out_index == M'(N - 1))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // The head slot drives the outputs and only moves on a transfer
      // or while empty, which keeps them stable under backpressure.
      case ({pend, xfer})
        2'b10: begin
          if (count == 2'd0) begin
            out_data  <= rd_data;
            out_index <= pend_idx;
            out_valid <= 1'b1;
          end else begin
            slot1_data <= rd_data;
            slot1_idx  <= pend_idx;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_data  <= slot1_data;
            out_index <= slot1_idx;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            out_data   <= slot1_data;
            out_index  <= slot1_idx;
            slot1_data <= rd_data;
            slot1_idx  <= pend_idx;
          end else begin
            out_data  <= rd_data;
            out_index <= pend_idx;
          end
        end
        default: ;
      endcase

      count <= count + 2'(pend) - 2'(xfer);
    end
  end

endmodule
`default_nettype wire
